time_setter: RTL and testbench

- Button-driven time editor that produces the preset time and load strobe consumed by the hours/minutes time-of-day counter.
- Debounces the mode/up/down push-buttons and seeds its edit registers from the counter's current time.
- Lets the user step hours (mod 24), then minutes (mod 60), then issues a single-cycle load with the edited value.
- Sits between the board buttons and the counter's timp_ore/timp_minute/load inputs.

---
 rtl/time_setter.sv | 198 +++++++++++++++++++
 tb/tb_time_setter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/time_setter.sv
// Button-driven hour/minute editor feeding the time-of-day counter's preset inputs.
// Each button is synchronized, debounced and turned into press (and optional auto-repeat) pulses.

module ts_button #(
    parameter int DEBOUNCE     = 4,
    parameter int REPEAT_EN    = 0,
    parameter int REPEAT_DELAY = 16,
    parameter int REPEAT_RATE  = 4
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic btn_i,
    output logic event_o
);
    localparam int DW   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    logic [1:0]    sync_q;
    logic          level_q, level_d;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic          press_q;
    logic          rep_q, rep_d;
    logic          started_q, started_d;
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;

    always_comb begin
        level_d  = level_q;
        db_cnt_d = '0;
        if (sync_q[1] != level_q) begin
            if (db_cnt_q == DW'(DEBOUNCE - 1)) level_d = sync_q[1];
            else                               db_cnt_d = db_cnt_q + DW'(1);
        end
    end

    // First repeat comes REPEAT_DELAY after the press, later ones every REPEAT_RATE.
    always_comb begin
        rep_d     = 1'b0;
        started_d = started_q;
        rep_cnt_d = rep_cnt_q;
        if (REPEAT_EN == 0 || !level_q) begin
            rep_cnt_d = '0;
            started_d = 1'b0;
        end else if (rep_cnt_q == (started_q ? RW'(REPEAT_RATE - 1) : RW'(REPEAT_DELAY - 1))) begin
            rep_d     = 1'b1;
            rep_cnt_d = '0;
            started_d = 1'b1;
        end else begin
            rep_cnt_d = rep_cnt_q + RW'(1);
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            sync_q    <= '0;
            level_q   <= 1'b0;
            db_cnt_q  <= '0;
            press_q   <= 1'b0;
            rep_q     <= 1'b0;
            started_q <= 1'b0;
            rep_cnt_q <= '0;
        end else begin
            sync_q    <= {sync_q[0], btn_i};
            level_q   <= level_d;
            db_cnt_q  <= db_cnt_d;
            press_q   <= level_d & ~level_q;
            rep_q     <= rep_d;
            started_q <= started_d;
            rep_cnt_q <= rep_cnt_d;
        end
    end

    assign event_o = press_q | rep_q;
endmodule

module time_setter #(
    parameter int DEBOUNCE     = 4,
    parameter int REPEAT_DELAY = 16,
    parameter int REPEAT_RATE  = 4,
    parameter int TIMEOUT      = 1024
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [4:0] cur_ore,
    input  logic [5:0] cur_minute,
    output logic [4:0] timp_ore,
    output logic [5:0] timp_minute,
    output logic       load,
    output logic       editing,
    output logic [1:0] edit_field
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_EDIT_H = 2'b01,
        S_EDIT_M = 2'b10,
        S_COMMIT = 2'b11
    } state_t;

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state_q, state_d;
    logic [4:0]    ore_q, ore_d;
    logic [5:0]    min_q, min_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [2:0]    btn_raw, btn_evt;
    logic          mode_ev, step_up, step_dn, any_ev, in_edit, tmo_hit;

    assign btn_raw = {btn_down, btn_up, btn_mode};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_btn
            ts_button #(
                .DEBOUNCE    (DEBOUNCE),
                .REPEAT_EN   ((gi != 0) ? 1 : 0),
                .REPEAT_DELAY(REPEAT_DELAY),
                .REPEAT_RATE (REPEAT_RATE)
            ) u_btn (
                .clock_i(clock),
                .reset_i(reset),
                .btn_i  (btn_raw[gi]),
                .event_o(btn_evt[gi])
            );
        end
    endgenerate

    // Mode beats a step; opposing steps cancel.
    assign mode_ev = btn_evt[0];
    assign step_up = btn_evt[1] & ~btn_evt[2] & ~mode_ev;
    assign step_dn = btn_evt[2] & ~btn_evt[1] & ~mode_ev;
    assign any_ev  = |btn_evt;
    assign in_edit = (state_q == S_EDIT_H) || (state_q == S_EDIT_M);
    assign tmo_hit = in_edit && !any_ev && (tmo_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ore_q   <= '0;
            min_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            ore_q   <= ore_d;
            min_q   <= min_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (mode_ev) state_d = S_EDIT_H;
            S_EDIT_H: if (mode_ev) state_d = S_EDIT_M; else if (tmo_hit) state_d = S_IDLE;
            S_EDIT_M: if (mode_ev) state_d = S_COMMIT; else if (tmo_hit) state_d = S_IDLE;
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tmo_d = '0;
        if (in_edit && !any_ev && !tmo_hit) tmo_d = tmo_q + TW'(1);
    end

    always_comb begin
        ore_d = ore_q;
        min_d = min_q;
        case (state_q)
            S_IDLE: if (mode_ev) begin
                ore_d = (cur_ore > 5'd23)    ? 5'd0 : cur_ore;
                min_d = (cur_minute > 6'd59) ? 6'd0 : cur_minute;
            end
            S_EDIT_H: begin
                if (step_up) ore_d = (ore_q >= 5'd23) ? 5'd0 : ore_q + 5'd1;
                if (step_dn) ore_d = (ore_q == 5'd0) ? 5'd23 : ore_q - 5'd1;
            end
            S_EDIT_M: begin
                if (step_up) min_d = (min_q >= 6'd59) ? 6'd0 : min_q + 6'd1;
                if (step_dn) min_d = (min_q == 6'd0) ? 6'd59 : min_q - 6'd1;
            end
            default: ;
        endcase
    end

    always_comb begin
        load       = (state_q == S_COMMIT);
        editing    = in_edit;
        edit_field = 2'b00;
        if (state_q == S_EDIT_H) edit_field = 2'b01;
        if (state_q == S_EDIT_M) edit_field = 2'b10;
    end

    assign timp_ore    = ore_q;
    assign timp_minute = min_q;
endmodule

// File: tb/tb_time_setter.sv
// Bench for time_setter: directed vector table, hand sequences for latency/repeat/timeout/reset,
// and random button traffic checked every cycle against an event-level reference model.
module tb_time_setter;
    localparam int DEB = 4, RD = 16, RR = 4, TO = 32;

    logic       clock, reset;
    logic       btn_mode, btn_up, btn_down;
    logic [4:0] cur_ore, timp_ore;
    logic [5:0] cur_minute, timp_minute;
    logic       load, editing;
    logic [1:0] edit_field;

    time_setter #(.DEBOUNCE(DEB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
        .cur_ore(cur_ore), .cur_minute(cur_minute), .timp_ore(timp_ore), .timp_minute(timp_minute),
        .load(load), .editing(editing), .edit_field(edit_field)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0, bad = 0;
    int load_cnt = 0, ld_h = 0, ld_m = 0;

    // Reference model: raw samples per edge, debounced levels, pending pulses, editor state.
    logic [2:0] rawh [0:16383];
    int         n;
    logic [2:0] lvl, pend;
    int         rise [3];
    int         mst, mh, mm, last;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        n = 0; lvl = '0; pend = '0;
        for (int b = 0; b < 3; b++) rise[b] = -100000;
        mst = 0; mh = 0; mm = 0; last = 0;
    endtask

    task automatic model_step();
        logic [2:0] ev;
        logic       flip, nl, p, r;
        int         m;
        n++;
        rawh[n] = {btn_down, btn_up, btn_mode};
        ev = pend;
        for (int b = 0; b < 3; b++) begin
            // Level flips once the synchronized value has differed for DEB edges in a row.
            flip = 1'b1;
            for (int j = 0; j < DEB; j++) begin
                m = n - j - 2;
                if (m < 1) flip = 1'b0;
                else if (rawh[m][b] == lvl[b]) flip = 1'b0;
            end
            nl = flip ? ~lvl[b] : lvl[b];
            p  = nl & ~lvl[b];
            if (p) rise[b] = n;
            r = (b != 0) && lvl[b] && (n - rise[b] >= RD) && (((n - rise[b] - RD) % RR) == 0);
            pend[b] = p | r;
            lvl[b]  = nl;
        end
        case (mst)
            0: if (ev[0]) begin
                mst = 1; last = n;
                mh = (cur_ore > 23) ? 0 : int'(cur_ore);
                mm = (cur_minute > 59) ? 0 : int'(cur_minute);
            end
            1, 2: begin
                if (ev != 0) last = n;
                if (ev[0]) mst = mst + 1;
                else if (ev[1] && !ev[2]) begin
                    if (mst == 1) mh = (mh + 1) % 24; else mm = (mm + 1) % 60;
                end else if (ev[2] && !ev[1]) begin
                    if (mst == 1) mh = (mh + 23) % 24; else mm = (mm + 59) % 60;
                end else if (ev == 0 && n - last >= TO) mst = 0;
            end
            default: mst = 0;
        endcase
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
        if (load) begin load_cnt++; ld_h = timp_ore; ld_m = timp_minute; end
        chk("m_ore", timp_ore, mh);
        chk("m_min", timp_minute, mm);
        chk("m_load", load, (mst == 3) ? 1 : 0);
        chk("m_editing", editing, (mst == 1 || mst == 2) ? 1 : 0);
        chk("m_field", edit_field, (mst == 1) ? 1 : (mst == 2) ? 2 : 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_ore", timp_ore, 0);
        chk("rst_min", timp_minute, 0);
        chk("rst_load", load, 0);
        chk("rst_editing", editing, 0);
        chk("rst_field", edit_field, 0);
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic press(input logic [2:0] b, input int hold, input int settle);
        {btn_down, btn_up, btn_mode} = b;
        repeat (hold) tick();
        {btn_down, btn_up, btn_mode} = 3'b000;
        repeat (settle) tick();
    endtask

    typedef struct {
        bit         rst;
        logic [2:0] btn;   // {down, up, mode}
        int         hold;
        logic [4:0] ch;
        logic [5:0] cm;
        int         eh, em, ef, eload;
    } vec_t;
    vec_t tbl [22];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        {btn_down, btn_up, btn_mode} = 3'b000;
        cur_ore = 5'd0; cur_minute = 6'd0;
        model_reset();

        tbl[0]  = '{1'b1, 3'b001, 10, 5'd13, 6'd45, 13, 45, 1, 0};
        tbl[1]  = '{1'b0, 3'b010,  8, 5'd0,  6'd0,  14, 45, 1, 0};
        tbl[2]  = '{1'b0, 3'b001,  8, 5'd0,  6'd0,  14, 45, 2, 0};
        tbl[3]  = '{1'b0, 3'b010,  8, 5'd0,  6'd0,  14, 46, 2, 0};
        tbl[4]  = '{1'b0, 3'b010,  8, 5'd0,  6'd0,  14, 47, 2, 0};
        tbl[5]  = '{1'b0, 3'b010,  8, 5'd0,  6'd0,  14, 48, 2, 0};
        tbl[6]  = '{1'b0, 3'b010,  8, 5'd0,  6'd0,  14, 49, 2, 0};
        tbl[7]  = '{1'b0, 3'b010,  8, 5'd0,  6'd0,  14, 50, 2, 0};
        tbl[8]  = '{1'b0, 3'b001,  8, 5'd0,  6'd0,  14, 50, 0, 1};
        tbl[9]  = '{1'b1, 3'b001,  8, 5'd22, 6'd1,  22,  1, 1, 0};
        tbl[10] = '{1'b0, 3'b010,  8, 5'd0,  6'd0,  23,  1, 1, 0};
        tbl[11] = '{1'b0, 3'b010,  8, 5'd0,  6'd0,   0,  1, 1, 0};
        tbl[12] = '{1'b0, 3'b010,  3, 5'd0,  6'd0,   0,  1, 1, 0};
        tbl[13] = '{1'b0, 3'b110,  8, 5'd0,  6'd0,   0,  1, 1, 0};
        tbl[14] = '{1'b0, 3'b011,  8, 5'd0,  6'd0,   0,  1, 2, 0};
        tbl[15] = '{1'b0, 3'b100,  8, 5'd0,  6'd0,   0,  0, 2, 0};
        tbl[16] = '{1'b0, 3'b100,  8, 5'd0,  6'd0,   0, 59, 2, 0};
        tbl[17] = '{1'b0, 3'b001,  8, 5'd0,  6'd0,   0, 59, 0, 1};
        tbl[18] = '{1'b1, 3'b001,  8, 5'd30, 6'd61,  0,  0, 1, 0};
        tbl[19] = '{1'b0, 3'b100,  8, 5'd0,  6'd0,  23,  0, 1, 0};
        tbl[20] = '{1'b0, 3'b001,  8, 5'd0,  6'd0,  23,  0, 2, 0};
        tbl[21] = '{1'b0, 3'b010,  8, 5'd0,  6'd0,  23,  1, 2, 0};

        #2;
        do_reset();

        for (int i = 0; i < 22; i++) begin
            if (tbl[i].rst) do_reset();
            cur_ore = tbl[i].ch; cur_minute = tbl[i].cm;
            load_cnt = 0;
            press(tbl[i].btn, tbl[i].hold, 8);
            chk($sformatf("v%0d_ore", i), timp_ore, tbl[i].eh);
            chk($sformatf("v%0d_min", i), timp_minute, tbl[i].em);
            chk($sformatf("v%0d_field", i), edit_field, tbl[i].ef);
            chk($sformatf("v%0d_loads", i), load_cnt, tbl[i].eload);
            if (tbl[i].eload != 0) begin
                chk($sformatf("v%0d_ld_ore", i), ld_h, tbl[i].eh);
                chk($sformatf("v%0d_ld_min", i), ld_m, tbl[i].em);
            end
        end

        // Press latency: raw rise to EDIT_H takes exactly 3+DEB edges.
        do_reset();
        cur_ore = 5'd13; cur_minute = 6'd45;
        btn_mode = 1'b1;
        repeat (3 + DEB - 1) tick();
        chk("lat_early_editing", editing, 0);
        tick();
        chk("lat_editing", editing, 1);
        chk("lat_field", edit_field, 1);
        chk("lat_ore", timp_ore, 13);
        chk("lat_min", timp_minute, 45);
        repeat (3) tick();
        btn_mode = 1'b0;
        repeat (8) tick();

        // Mode held through reset still needs the full debounce, then timeout with no load.
        btn_mode = 1'b1;
        do_reset();
        repeat (3 + DEB - 1) tick();
        chk("held_early_editing", editing, 0);
        tick();
        chk("held_editing", editing, 1);
        load_cnt = 0;
        repeat (3) tick();
        btn_mode = 1'b0;
        repeat (TO - 1 - 3) tick();
        chk("tmo_early_editing", editing, 1);
        tick();
        chk("tmo_editing", editing, 0);
        chk("tmo_field", edit_field, 0);
        chk("tmo_loads", load_cnt, 0);
        chk("tmo_ore", timp_ore, 13);
        chk("tmo_min", timp_minute, 45);

        // Auto-repeat: press plus three repeats in EDIT_M from minute 0.
        do_reset();
        cur_ore = 5'd0; cur_minute = 6'd0;
        press(3'b001, 8, 8);
        press(3'b001, 8, 8);
        press(3'b010, 26, 10);
        chk("rep_min", timp_minute, 4);
        chk("rep_ore", timp_ore, 0);
        chk("rep_field", edit_field, 2);

        // Async reset mid-edit clears everything before the next edge.
        chk("pre_rst_editing", editing, 1);
        #2;
        do_reset();

        // Random button traffic against the model.
        for (int seg = 0; seg < 160; seg++) begin
            int sel, dur;
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2: {btn_down, btn_up, btn_mode} = 3'b000;
                3, 4:    {btn_down, btn_up, btn_mode} = 3'b001;
                5, 6:    {btn_down, btn_up, btn_mode} = 3'b010;
                7:       {btn_down, btn_up, btn_mode} = 3'b100;
                8:       {btn_down, btn_up, btn_mode} = 3'b110;
                default: {btn_down, btn_up, btn_mode} = 3'($urandom_range(0, 7));
            endcase
            cur_ore    = 5'($urandom_range(0, 31));
            cur_minute = 6'($urandom_range(0, 63));
            dur = (sel < 3) ? $urandom_range(1, 45) : $urandom_range(1, 30);
            repeat (dur) tick();
            if ($urandom_range(0, 59) == 0) do_reset();
        end
        {btn_down, btn_up, btn_mode} = 3'b000;
        repeat (10) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
